// File: rtl/router_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_ctrl_pkg
// Description : Shared types and constants for the router_ctrl packet sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package router_ctrl_pkg;

    localparam int NDEST   = 8;
    localparam int DEST_W  = 3;
    localparam int LEN_W   = 5;
    localparam int LEN_LSB = 3;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_payload = 2'd1;
    localparam logic [1:0] c_st_drop    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = c_st_idle,
        PAYLOAD = c_st_payload,
        DROP    = c_st_drop
    } state_t;

    function automatic logic [NDEST-1:0] dest_onehot(input logic [DEST_W-1:0] d);
        return NDEST'(1) << d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_ctrl_oreg.sv
`default_nettype none
// ============================================================================
// Module      : router_ctrl_oreg
// Description : One-entry valid/ready holding register; a load wins over a drain.
// Revision    : 1.0 - initial release
// ============================================================================
module router_ctrl_oreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_drain,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);

    logic             r_vld;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_vld  <= 1'b1;
            r_data <= i_data;
        end else if (i_drain) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/router_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : router_ctrl
// Description : Header-decoding packet sequencer feeding router_1to8.
//               ROUTER_CTRL_STATS_EN adds the saturating drop_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module router_ctrl
    import router_ctrl_pkg::*;
#(
    parameter logic [NDEST-1:0] DEST_MASK_RST = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NDEST-1:0]  en_mask,
    output logic [DEST_W-1:0] sel,
    output logic [7:0]        data,
    output logic [NDEST-1:0]  out_valid,
    input  logic [NDEST-1:0]  out_ready,
    output logic              busy,
    output logic              pkt_done
`ifdef ROUTER_CTRL_STATS_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    state_t             r_state;
    logic [DEST_W-1:0]  r_sel;
    logic [LEN_W-1:0]   r_rem;
    logic [NDEST-1:0]   r_en_snap;

    logic               w_vld;
    logic [7:0]         w_data;
    logic               w_drain;
    logic               w_in_ready;
    logic               w_acc;
    logic               w_hdr_acc;
    logic               w_fwd_acc;
    logic               w_last;
    logic [DEST_W-1:0]  w_hdr_dest;
    logic [LEN_W-1:0]   w_hdr_len;
    logic               w_hdr_en;

    assign w_drain    = out_ready[r_sel];
    assign w_in_ready = (r_state == DROP) | ~w_vld | w_drain;
    assign w_acc      = in_valid & w_in_ready;
    assign w_hdr_dest = in[DEST_W-1:0];
    assign w_hdr_len  = in[LEN_LSB +: LEN_W];
    assign w_hdr_en   = en_mask[w_hdr_dest];
    assign w_hdr_acc  = w_acc & (r_state == IDLE);
    assign w_last     = (r_rem == '0);
    // The mask snapshot taken at header time keeps mid-packet en_mask edits inert.
    assign w_fwd_acc  = w_acc & (r_state == PAYLOAD) & r_en_snap[r_sel];

    // sel only moves on an enabled header; header accept implies the register is
    // empty or draining, so the new sel never coincides with a stale valid byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_rem     <= '0;
            r_en_snap <= DEST_MASK_RST;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hdr_acc) begin
                        r_rem     <= w_hdr_len;
                        r_en_snap <= en_mask;
                        if (w_hdr_en) begin
                            r_sel   <= w_hdr_dest;
                            r_state <= PAYLOAD;
                        end else begin
                            r_state <= DROP;
                        end
                    end
                end
                PAYLOAD, DROP: begin
                    if (w_acc) begin
                        if (w_last) r_state <= IDLE;
                        else        r_rem   <= r_rem - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    router_ctrl_oreg #(
        .WIDTH (8)
    ) u_oreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_fwd_acc),
        .i_drain (w_drain),
        .i_data  (in),
        .o_vld   (w_vld),
        .o_data  (w_data)
    );

`ifdef ROUTER_CTRL_STATS_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_hdr_acc && !w_hdr_en && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign in_ready  = w_in_ready;
    assign sel       = r_sel;
    assign data      = w_data;
    assign out_valid = w_vld ? dest_onehot(r_sel) : '0;
    assign busy      = (r_state != IDLE) | w_vld;
    assign pkt_done  = w_fwd_acc & w_last;

endmodule
`default_nettype wire

// File: tb/tb_router_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_ctrl
// Description : Directed + randomized bench for router_ctrl with a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  en_mask;
    logic [2:0]  sel;
    logic [7:0]  data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic        busy;
    logic        pkt_done;
`ifdef ROUTER_CTRL_STATS_EN
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    router_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .en_mask   (en_mask),
        .sel       (sel),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .pkt_done  (pkt_done)
`ifdef ROUTER_CTRL_STATS_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    logic [10:0] exp_q[$];   // {dest, byte} accepted but not yet handed to a sink
    bit          m_in_pkt, m_fwd, acc_flag, rnd_mode;
    int          m_left, m_drops;
    logic [2:0]  m_dest;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] oh(input logic [2:0] d);
        return 8'd1 << d;
    endfunction

    // Mid-cycle observer: checks every output against the packet model, then commits accepts.
    task automatic monitor();
        logic exp_rdy;
        logic acc;
        acc_flag = 1'b0;
        if (rst) begin
            exp_q.delete();
            m_in_pkt = 1'b0;
            return;
        end
        chk("busy", busy, m_in_pkt || exp_q.size() != 0);
        if (m_in_pkt && !m_fwd) exp_rdy = 1'b1;
        else if (exp_q.size() == 0) exp_rdy = 1'b1;
        else exp_rdy = out_ready[exp_q[0][10:8]];
        chk("in_ready", in_ready, exp_rdy);
        if (exp_q.size() == 0) begin
            chk("out_valid_idle", out_valid, 8'h00);
        end else begin
            chk("out_valid", out_valid, oh(exp_q[0][10:8]));
            chk("data", data, exp_q[0][7:0]);
            chk("sel", sel, exp_q[0][10:8]);
            if (out_ready[exp_q[0][10:8]]) void'(exp_q.pop_front());
        end
        acc = in_valid && in_ready;
        acc_flag = acc;
        chk("pkt_done", pkt_done, acc && m_in_pkt && m_fwd && m_left == 0);
        if (acc) begin
            if (!m_in_pkt) begin
                m_dest   = in[2:0];
                m_left   = int'(in[7:3]);
                m_fwd    = en_mask[in[2:0]];
                m_in_pkt = 1'b1;
                if (!m_fwd) m_drops++;
            end else begin
                if (m_fwd) exp_q.push_back({m_dest, in});
                if (m_left == 0) m_in_pkt = 1'b0;
                else m_left--;
            end
        end
    endtask

    task automatic cyc();
        if (rnd_mode) begin
            out_ready = 8'($urandom | $urandom);
            en_mask   = 8'($urandom);
        end
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in = b;
        in_valid = 1'b1;
        do begin
            cyc();
            n++;
        end while (!acc_flag && n < 200);
        in_valid = 1'b0;
        if (!acc_flag) begin
            total++;
            bad++;
            $error("FAIL accept_timeout: observed=no_accept expected=accept byte=%0h", b);
        end
    endtask

    initial begin
        logic [7:0] hdr;
        rst = 1'b1; in = 8'h00; in_valid = 1'b0; en_mask = 8'hFF; out_ready = 8'hFF;
        rnd_mode = 1'b0; m_in_pkt = 1'b0; m_fwd = 1'b0; m_left = 0; m_drops = 0; m_dest = 3'd0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_sel", sel, 3'd0);
        chk("rst_data", data, 8'h00);
        chk("rst_out_valid", out_valid, 8'h00);
        chk("rst_pkt_done", pkt_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
`ifdef ROUTER_CTRL_STATS_EN
        chk("rst_drop_cnt", drop_cnt, 16'd0);
`endif

        // forward 13 AA BB CC
        send_byte(8'h13); send_byte(8'hAA);
        #1;
        chk("fwd_sel", sel, 3'd3);
        chk("fwd_out_valid", out_valid, 8'h08);
        chk("fwd_data", data, 8'hAA);
        send_byte(8'hBB); send_byte(8'hCC);
        cyc();

        // backpressure on sink 3
        out_ready = 8'hF7;
        send_byte(8'h13); send_byte(8'hAA);
        in = 8'hBB; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_data", data, 8'hAA);
            chk("bp_out_valid", out_valid, 8'h08);
            chk("bp_in_ready", in_ready, 1'b0);
            cyc();
        end
        out_ready = 8'hFF;
        send_byte(8'hBB); send_byte(8'hCC);
        cyc();

        // drop to disabled dest 3
        en_mask = 8'hF7;
        send_byte(8'h0B); send_byte(8'h11); send_byte(8'h22);
        cyc();
`ifdef ROUTER_CTRL_STATS_EN
        chk("drop_cnt_one", drop_cnt, 16'd1);
`endif
        en_mask = 8'hFF;

        // back-to-back: single-byte packet to dest 0 stalled, then header to dest 5
        out_ready = 8'hFE;
        send_byte(8'h00); send_byte(8'hDD);
        in = 8'h05; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("b2b_sel_hold", sel, 3'd0);
            chk("b2b_in_ready", in_ready, 1'b0);
            cyc();
        end
        out_ready = 8'hFF;
        #1;
        chk("b2b_in_ready_rel", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("b2b_sel_new", sel, 3'd5);
        chk("b2b_no_spurious", out_valid, 8'h00);
        send_byte(8'h5A);
        #1;
        chk("b2b_out_valid5", out_valid, 8'h20);
        cyc();

        // reset mid-packet
        send_byte(8'h1B); send_byte(8'h01);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        send_byte(8'h02); send_byte(8'h77);
        #1;
        chk("mid_rst_out_valid4", out_valid, 8'h04);
        chk("mid_rst_data", data, 8'h77);
        cyc();

        // maximum length packet
        send_byte(8'hF8);
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        #1;
        chk("max_last_data", data, 8'h1F);
        cyc();
        chk("max_idle", busy, 1'b0);

        // randomized traffic with random sink readiness and mask churn
        rnd_mode = 1'b1;
        repeat (40) begin
            hdr = 8'($urandom);
            send_byte(hdr);
            repeat (int'(hdr[7:3]) + 1) begin
                repeat ($urandom_range(0, 1)) cyc();
                send_byte(8'($urandom));
            end
        end
        rnd_mode = 1'b0;
        out_ready = 8'hFF;
        repeat (3) cyc();
        chk("end_busy", busy, 1'b0);
        chk("end_queue_empty", exp_q.size(), 0);
`ifdef ROUTER_CTRL_STATS_EN
        chk("end_drop_cnt", drop_cnt, m_drops[15:0]);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
